rs_iss_sel: RTL and testbench

Issue-select stage directly downstream of the reservation-station entries. Each cycle it takes the per-entry ready vector and entry fields, picks one ready entry whose FU select matches this instance's FU class, pulses that entry's issue enable, and captures the instruction into a one-deep issue register feeding the functional unit. It owns round-robin fairness, FU back-pressure and branch squash/mask update of the instruction it holds. One instance exists per FU class.

---
 rtl/rs_iss_sel.sv | 128 ++++++++++++
 tb/tb_rs_iss_sel.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_iss_sel.sv
// Issue-select stage for one FU class: round-robin pick among ready RS entries,
// one-deep issue register with FU back-pressure and branch squash/mask update.
module rs_iss_sel #(
    parameter int RS_NUM    = 8,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int BR_MASK_W = 5,
    parameter int FU_SEL_W  = 3,
    parameter int FU_ID     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RS_NUM-1:0]             ent_rdy_i,
    input  logic [RS_NUM*FU_SEL_W-1:0]    ent_fu_sel_i,
    input  logic [RS_NUM*PRF_IDX_W-1:0]   ent_opa_tag_i,
    input  logic [RS_NUM*PRF_IDX_W-1:0]   ent_opb_tag_i,
    input  logic [RS_NUM*PRF_IDX_W-1:0]   ent_dest_tag_i,
    input  logic [RS_NUM*32-1:0]          ent_IR_i,
    input  logic [RS_NUM*ROB_IDX_W-1:0]   ent_rob_idx_i,
    input  logic [RS_NUM*BR_MASK_W-1:0]   ent_br_mask_i,
    input  logic                          br_pred_correct_i,
    input  logic                          br_recovery_i,
    input  logic [BR_MASK_W-1:0]          br_tag_fix_i,
    input  logic                          fu_rdy_i,
    output logic [RS_NUM-1:0]             ent_iss_en_o,
    output logic                          iss_vld_o,
    output logic [PRF_IDX_W-1:0]          iss_opa_tag_o,
    output logic [PRF_IDX_W-1:0]          iss_opb_tag_o,
    output logic [PRF_IDX_W-1:0]          iss_dest_tag_o,
    output logic [31:0]                   iss_IR_o,
    output logic [ROB_IDX_W-1:0]          iss_rob_idx_o,
    output logic [BR_MASK_W-1:0]          iss_br_mask_o
);

    localparam int PTR_W = $clog2(RS_NUM);

    logic [FU_SEL_W-1:0]  fu_sel   [RS_NUM];
    logic [PRF_IDX_W-1:0] opa_tag  [RS_NUM];
    logic [PRF_IDX_W-1:0] opb_tag  [RS_NUM];
    logic [PRF_IDX_W-1:0] dest_tag [RS_NUM];
    logic [31:0]          ir       [RS_NUM];
    logic [ROB_IDX_W-1:0] rob_idx  [RS_NUM];
    logic [BR_MASK_W-1:0] br_mask  [RS_NUM];
    logic [RS_NUM-1:0]    cand;

    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     scan_idx;
    logic                 found;
    logic                 grant;
    logic                 kill;
    logic                 slot_free;
    logic [BR_MASK_W-1:0] pred_clear;

    // Entries that depend on a branch being recovered this cycle are never candidates.
    for (genvar i = 0; i < RS_NUM; i++) begin : g_ent
        assign fu_sel[i]   = ent_fu_sel_i[i*FU_SEL_W +: FU_SEL_W];
        assign opa_tag[i]  = ent_opa_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
        assign opb_tag[i]  = ent_opb_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
        assign dest_tag[i] = ent_dest_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
        assign ir[i]       = ent_IR_i[i*32 +: 32];
        assign rob_idx[i]  = ent_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
        assign br_mask[i]  = ent_br_mask_i[i*BR_MASK_W +: BR_MASK_W];
        assign cand[i]     = ent_rdy_i[i] & (fu_sel[i] == FU_SEL_W'(FU_ID))
                             & ~(br_recovery_i & |(br_mask[i] & br_tag_fix_i));
    end

    assign kill       = br_recovery_i & |(iss_br_mask_o & br_tag_fix_i);
    assign slot_free  = ~iss_vld_o | fu_rdy_i | kill;
    assign pred_clear = br_pred_correct_i ? br_tag_fix_i : '0;

    // Round-robin scan starting at ptr; index arithmetic wraps since RS_NUM is a power of two.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < RS_NUM; k++) begin
            scan_idx = ptr + PTR_W'(k);
            if (!found && cand[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign grant        = slot_free & found & ~rst;
    assign ent_iss_en_o = grant ? (RS_NUM'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= grant_idx + PTR_W'(1);
        end
    end

    // A new grant overrides both drain and squash of the held instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_o      <= 1'b0;
            iss_opa_tag_o  <= '0;
            iss_opb_tag_o  <= '0;
            iss_dest_tag_o <= '0;
            iss_IR_o       <= '0;
            iss_rob_idx_o  <= '0;
            iss_br_mask_o  <= '0;
        end else if (grant) begin
            iss_vld_o      <= 1'b1;
            iss_opa_tag_o  <= opa_tag[grant_idx];
            iss_opb_tag_o  <= opb_tag[grant_idx];
            iss_dest_tag_o <= dest_tag[grant_idx];
            iss_IR_o       <= ir[grant_idx];
            iss_rob_idx_o  <= rob_idx[grant_idx];
            iss_br_mask_o  <= br_mask[grant_idx] & ~pred_clear;
        end else if (kill || (iss_vld_o && fu_rdy_i)) begin
            iss_vld_o      <= 1'b0;
            iss_opa_tag_o  <= '0;
            iss_opb_tag_o  <= '0;
            iss_dest_tag_o <= '0;
            iss_IR_o       <= '0;
            iss_rob_idx_o  <= '0;
            iss_br_mask_o  <= '0;
        end else begin
            iss_br_mask_o  <= iss_br_mask_o & ~pred_clear;
        end
    end

endmodule

// File: tb/tb_rs_iss_sel.sv
// Directed bench for rs_iss_sel: stimulus pushes per-cycle expectations into a
// queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_rs_iss_sel;

    localparam int RS_NUM = 8;
    localparam int PW     = 6;
    localparam int RW     = 5;
    localparam int BW     = 5;
    localparam int FW     = 3;
    localparam int FU_ID  = 1;

    typedef struct {
        logic [7:0] en;
        logic       vld;
        int         ent;
        logic [4:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [RS_NUM-1:0]    ent_rdy = '0;
    logic [RS_NUM*FW-1:0] ent_fu_sel;
    logic [RS_NUM*PW-1:0] ent_opa, ent_opb, ent_dest;
    logic [RS_NUM*32-1:0] ent_ir;
    logic [RS_NUM*RW-1:0] ent_rob;
    logic [RS_NUM*BW-1:0] ent_msk;
    logic                 br_pc = 1'b0, br_rec = 1'b0, fu_rdy = 1'b0;
    logic [BW-1:0]        br_tag = '0;

    logic [RS_NUM-1:0]    iss_en;
    logic                 iss_vld;
    logic [PW-1:0]        iss_opa, iss_opb, iss_dest;
    logic [31:0]          iss_ir;
    logic [RW-1:0]        iss_rob;
    logic [BW-1:0]        iss_mask;

    logic [FW-1:0] sel_arr  [RS_NUM];
    logic [BW-1:0] mask_arr [RS_NUM];

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_iss_sel #(
        .RS_NUM(RS_NUM), .PRF_IDX_W(PW), .ROB_IDX_W(RW),
        .BR_MASK_W(BW), .FU_SEL_W(FW), .FU_ID(FU_ID)
    ) dut (
        .clk(clk), .rst(rst),
        .ent_rdy_i(ent_rdy), .ent_fu_sel_i(ent_fu_sel),
        .ent_opa_tag_i(ent_opa), .ent_opb_tag_i(ent_opb), .ent_dest_tag_i(ent_dest),
        .ent_IR_i(ent_ir), .ent_rob_idx_i(ent_rob), .ent_br_mask_i(ent_msk),
        .br_pred_correct_i(br_pc), .br_recovery_i(br_rec), .br_tag_fix_i(br_tag),
        .fu_rdy_i(fu_rdy), .ent_iss_en_o(iss_en), .iss_vld_o(iss_vld),
        .iss_opa_tag_o(iss_opa), .iss_opb_tag_o(iss_opb), .iss_dest_tag_o(iss_dest),
        .iss_IR_o(iss_ir), .iss_rob_idx_o(iss_rob), .iss_br_mask_o(iss_mask)
    );

    // Each entry carries fixed, distinguishable fields derived from its index.
    function automatic logic [PW-1:0] opa_of(int i);  return PW'(i + 1);  endfunction
    function automatic logic [PW-1:0] opb_of(int i);  return PW'(i + 20); endfunction
    function automatic logic [PW-1:0] dest_of(int i); return PW'(i + 40); endfunction
    function automatic logic [31:0]   ir_of(int i);   return 32'hC0DE_0000 | 32'(i); endfunction
    function automatic logic [RW-1:0] rob_of(int i);  return RW'(i + 3);  endfunction

    always_comb begin
        ent_fu_sel = '0;
        ent_opa    = '0;
        ent_opb    = '0;
        ent_dest   = '0;
        ent_ir     = '0;
        ent_rob    = '0;
        ent_msk    = '0;
        for (int i = 0; i < RS_NUM; i++) begin
            ent_fu_sel[i*FW +: FW] = sel_arr[i];
            ent_opa[i*PW +: PW]    = opa_of(i);
            ent_opb[i*PW +: PW]    = opb_of(i);
            ent_dest[i*PW +: PW]   = dest_of(i);
            ent_ir[i*32 +: 32]     = ir_of(i);
            ent_rob[i*RW +: RW]    = rob_of(i);
            ent_msk[i*BW +: BW]    = mask_arr[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check("iss_en", 32'(iss_en), 32'(e.en));
        check("iss_vld", 32'(iss_vld), 32'(e.vld));
        check("iss_rob", 32'(iss_rob), e.vld ? 32'(rob_of(e.ent)) : 32'h0);
        check("iss_ir", iss_ir, e.vld ? ir_of(e.ent) : 32'h0);
        check("iss_opa", 32'(iss_opa), e.vld ? 32'(opa_of(e.ent)) : 32'h0);
        check("iss_opb", 32'(iss_opb), e.vld ? 32'(opb_of(e.ent)) : 32'h0);
        check("iss_dest", 32'(iss_dest), e.vld ? 32'(dest_of(e.ent)) : 32'h0);
        check("iss_mask", 32'(iss_mask), e.vld ? 32'(e.mask) : 32'h0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) checkOutput(q.pop_front());
    end

    task automatic applyStimulus(input logic [7:0] rdy, input logic frdy, input logic pc,
                                 input logic rec, input logic [4:0] tag,
                                 input logic [7:0] x_en, input logic x_vld,
                                 input int x_ent, input logic [4:0] x_mask);
        exp_t e;
        ent_rdy = rdy;
        fu_rdy  = frdy;
        br_pc   = pc;
        br_rec  = rec;
        br_tag  = tag;
        e.en = x_en; e.vld = x_vld; e.ent = x_ent; e.mask = x_mask;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g[5] = '{0, 1, 2, 4, 5};
        int guard;
        for (int i = 0; i < RS_NUM; i++) begin
            sel_arr[i]  = FW'(FU_ID);
            mask_arr[i] = '0;
        end
        @(posedge clk);
        #1;
        // Reset cycle: candidates present but no grant allowed
        applyStimulus(8'h05, 1, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00);
        rst = 1'b0;

        // Two ready entries issue in consecutive cycles
        applyStimulus(8'h05, 1, 0, 0, 5'h00, 8'h01, 0, 0, 5'h00);
        applyStimulus(8'h04, 1, 0, 0, 5'h00, 8'h04, 1, 0, 5'h00);
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 1, 2, 5'h00);
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00);

        // Fairness with wrap, from ptr 0
        rst = 1'b1;
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00);
        rst = 1'b0;
        for (int k = 0; k < 9; k++)
            applyStimulus(8'hFF, 1, 0, 0, 5'h00, 8'(1 << (k % 8)), k > 0, (k + 7) % 8, 5'h00);
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 1, 0, 5'h00);
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00);

        // Entry 3 belongs to another FU class and is skipped
        rst = 1'b1;
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00);
        rst = 1'b0;
        sel_arr[3] = 3'd2;
        for (int j = 0; j < 5; j++)
            applyStimulus(8'hFF, 1, 0, 0, 5'h00, 8'(1 << g[j]), j > 0, (j > 0) ? g[(j + 4) % 5] : 0, 5'h00);
        sel_arr[3] = FW'(FU_ID);

        // Back-pressure stall, then release issues in the same cycle
        applyStimulus(8'h00, 0, 0, 0, 5'h00, 8'h00, 1, 5, 5'h00);
        for (int s = 0; s < 3; s++)
            applyStimulus(8'h10, 0, 0, 0, 5'h00, 8'h00, 1, 5, 5'h00);
        applyStimulus(8'h10, 1, 0, 0, 5'h00, 8'h10, 1, 5, 5'h00);
        applyStimulus(8'h00, 0, 0, 0, 5'h00, 8'h00, 1, 4, 5'h00);

        // Squash of the held instruction: unrelated tag keeps it, matching tag drops it
        mask_arr[6] = 5'b00100;
        applyStimulus(8'h40, 1, 0, 0, 5'h00, 8'h40, 1, 4, 5'h00);
        applyStimulus(8'h00, 0, 0, 1, 5'b00010, 8'h00, 1, 6, 5'b00100);
        applyStimulus(8'h00, 0, 0, 0, 5'h00, 8'h00, 1, 6, 5'b00100);
        applyStimulus(8'h00, 0, 0, 1, 5'b00100, 8'h00, 1, 6, 5'b00100);
        applyStimulus(8'h00, 0, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00);
        mask_arr[6] = '0;

        // Dependent candidate is never granted during recovery
        mask_arr[1] = 5'b01000;
        applyStimulus(8'h02, 1, 0, 1, 5'b01000, 8'h00, 0, 0, 5'h00);
        applyStimulus(8'h06, 1, 0, 1, 5'b01000, 8'h04, 0, 0, 5'h00);
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 1, 2, 5'h00);
        applyStimulus(8'h00, 0, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00);
        mask_arr[1] = '0;

        // Correct prediction clears the resolved bit in held and newly loaded masks
        mask_arr[3] = 5'b00110;
        mask_arr[4] = 5'b00011;
        applyStimulus(8'h08, 1, 0, 0, 5'h00, 8'h08, 0, 0, 5'h00);
        applyStimulus(8'h00, 0, 1, 0, 5'b00010, 8'h00, 1, 3, 5'b00110);
        applyStimulus(8'h10, 1, 1, 0, 5'b00001, 8'h10, 1, 3, 5'b00100);
        applyStimulus(8'h00, 0, 0, 0, 5'h00, 8'h00, 1, 4, 5'b00010);

        // Kill and grant together: the new instruction replaces the squashed one
        applyStimulus(8'h20, 0, 0, 1, 5'b00010, 8'h20, 1, 4, 5'b00010);
        applyStimulus(8'h00, 0, 0, 0, 5'h00, 8'h00, 1, 5, 5'h00);

        // Reset mid-operation drops the held instruction and rewinds the pointer
        rst = 1'b1;
        applyStimulus(8'hFF, 0, 0, 0, 5'h00, 8'h00, 1, 5, 5'h00);
        rst = 1'b0;
        applyStimulus(8'hFF, 1, 0, 0, 5'h00, 8'h01, 0, 0, 5'h00);
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 1, 0, 5'h00);
        applyStimulus(8'h00, 1, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00);

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
